imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Registered, parametrised immediate generator for the pipelined core. It sits between the decode stage and the ID/EX register and decodes every RV32I/RV64I immediate format, including U-type, shift amounts and CSR zimm, at XLEN width. A valid/ready handshake with a two-entry skid buffer lets the execute stage stall without a combinational path from out_ready back to in_ready. A synchronous flush kills in-flight entries on branch redirect.

## Interface
- XLEN, 32: datapath width; legal values 32 and 64 only.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all buffered entries.
- in_valid  in  1  instruction/selector pair offered.
- in_ready  out  1  buffer can accept this cycle.
- instr  in  32  full instruction word.
- imm_src  in  3  format select (see Operation).
- out_valid  out  1  imm/imm_err hold a valid result.
- out_ready  in  1  consumer accepts this cycle.
- imm  out  XLEN  extended immediate.
- imm_err  out  1  selector was reserved (111).

## Operation
- imm_src decode, with s = instr[31]:
  - 000 I: sign-extend instr[31:20].
  - 001 S: sign-extend {instr[31:25], instr[11:7]}.
  - 010 B: sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - 011 J: sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - 100 U: {instr[31:12], 12'b0}, then sign-extend from bit 31 to XLEN.
  - 101 SHAMT: zero-extend instr[25:20] when XLEN=64, instr[24:20] when XLEN=32.
  - 110 ZIMM: zero-extend instr[19:15].
  - 111: imm=0, imm_err=1. For every other code imm_err=0.
- Storage: output register (main) plus one skid register, each holding {imm, imm_err, valid}.
- in_ready = !skid_valid. It is a registered state bit only and never depends on out_ready.
- Input fire = in_valid & in_ready. Output fire = out_valid & out_ready.
- Per-edge rules when flush=0:
  - main empty, input fires: the decoded value loads main.
  - main full, output fires, skid empty: main loads the input if one fires, otherwise main empties.
  - main full, output fires, skid full: skid moves to main and skid empties. No input fires in this case because in_ready=0.
  - main full, no output fire, input fires: the decoded value loads skid.
- Ordering is strict FIFO. Nothing is dropped or duplicated.
- flush=1 at an edge: main and skid valids clear. A same-cycle input fire is discarded. Flush wins over every other event.
- The XLEN parameter check is elaboration-time. Any value other than 32 or 64 is a fatal error.

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, imm=0, imm_err=0, skid cleared, in_ready=1. Values hold until the first rising edge after rst_n deasserts.
- Latency: input fire at edge N gives out_valid=1 after edge N, with that result.
- Throughput: 1 per cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, imm and imm_err hold stable. in_ready falls after the edge that fills skid.
- Recovery: the first output fire with skid full refills main from skid, and in_ready returns to 1 after that edge.
- Reset mid-operation: all contents are lost immediately. No output fire is reported for buffered data.
- No combinational path exists from any input to any output. imm and imm_err are driven from the main register only.

## Test plan
- Reset: assert rst_n=0 mid-stream with both entries full. Required: out_valid=0 and in_ready=1 immediately, imm=0 and imm_err=0.
- Format sweep, XLEN=32, out_ready=1. Each pair below must appear one cycle after input, back-to-back:
  - 0xFFF00093, sel 000 -> imm=0xFFFFFFFF.
  - 0xFE000EE3, sel 010 -> imm=0xFFFFFFFC.
  - 0x0080006F, sel 011 -> imm=0x00000008.
  - sel 111 -> imm=0, imm_err=1.
- XLEN=64:
  - 0x800000B7, sel 100 -> imm=0xFFFFFFFF80000000.
  - 0x03F09093, sel 101 -> imm=63.
  - Same word with XLEN=32 -> imm=31.
- Stall/skid: stream A, B, C with out_ready=0 from the cycle A appears. Required:
  - A holds on the output and B lands in skid.
  - in_ready drops, so C is held.
  - Raise out_ready: the output order is A, B, C with no gaps after the stall releases.
- Flush: flush=1 with main and skid full and in_valid=1 on the same edge. Required: next cycle out_valid=0 and in_ready=1, and the flushed input never appears.
- Random: random in_valid, out_ready and flush against a scoreboard model. Required: FIFO order holds, no loss, and imm stays stable while stalled.

Source files
------------

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: decode-side input channel, execute-side
// output channel and the branch-redirect flush.
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [2:0]      imm_src;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] imm;
    logic            imm_err;

    // Producer/consumer side that drives instructions in and accepts results.
    modport master (
        output flush, in_valid, instr, imm_src, out_ready,
        input  in_ready, out_valid, imm, imm_err
    );

    // The immediate generator itself.
    modport slave (
        input  flush, in_valid, instr, imm_src, out_ready,
        output in_ready, out_valid, imm, imm_err
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RV32I/RV64I immediate generator. A main output register plus one
// skid register give full throughput with in_ready taken purely from state,
// so out_ready never reaches in_ready combinationally. flush kills both.
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    imm_gen_pipe_if.slave bus
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
            $fatal(1, "imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    typedef enum logic [2:0] {
        SRC_I     = 3'b000,
        SRC_S     = 3'b001,
        SRC_B     = 3'b010,
        SRC_J     = 3'b011,
        SRC_U     = 3'b100,
        SRC_SHAMT = 3'b101,
        SRC_ZIMM  = 3'b110,
        SRC_RSVD  = 3'b111
    } imm_src_e;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic            err;
    } entry_t;

    logic signed [31:0] dec32;
    logic               dec_err;
    entry_t             dec;
    entry_t             main_q;
    entry_t             skid_q;
    logic               main_valid;
    logic               skid_valid;
    logic               in_fire;
    logic               out_fire;

    // The opcode field carries no immediate bits.
    logic unused_opcode;
    assign unused_opcode = ^bus.instr[6:0];

    // Decode the selected format to a signed 32-bit value; every format fits
    // in 32 bits and shamt/zimm have bit 31 clear, so one sign-extension to
    // XLEN covers both the sign- and zero-extended cases.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would infer a latch.
        dec32   = '0;
        dec_err = 1'b0;
        case (imm_src_e'(bus.imm_src))
            SRC_I:     dec32 = {{20{bus.instr[31]}}, bus.instr[31:20]};
            SRC_S:     dec32 = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
            SRC_B:     dec32 = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                                bus.instr[30:25], bus.instr[11:8], 1'b0};
            SRC_J:     dec32 = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                                bus.instr[20], bus.instr[30:21], 1'b0};
            SRC_U:     dec32 = {bus.instr[31:12], 12'b0};
            SRC_SHAMT: dec32 = (XLEN == 64) ? {26'b0, bus.instr[25:20]}
                                            : {27'b0, bus.instr[24:20]};
            SRC_ZIMM:  dec32 = {27'b0, bus.instr[19:15]};
            default:   dec_err = 1'b1;
        endcase
    end

    assign dec.imm = XLEN'(dec32);
    assign dec.err = dec_err;

    assign in_fire  = bus.in_valid & ~skid_valid;
    assign out_fire = main_valid & bus.out_ready;

    // Main/skid buffer update: strict FIFO, flush overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: data registers are reset as well as the valids because
            // imm/imm_err must read zero straight out of reset.
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (bus.flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid) begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge state regardless of statement order.
            if (in_fire) begin
                main_q     <= dec;
                main_valid <= 1'b1;
            end
        end else if (out_fire) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                skid_valid <= 1'b0;
            end else if (in_fire) begin
                main_q <= dec;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (in_fire) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end

    assign bus.in_ready  = ~skid_valid;
    assign bus.out_valid = main_valid;
    assign bus.imm       = main_q.imm;
    assign bus.imm_err   = main_q.err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus
// stream; a scoreboard queue per instance is filled by the driver and
// drained by a negedge monitor against a behavioural immediate model.
module tb_imm_gen_pipe;

    typedef struct {
        logic [63:0] imm;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] instr = '0;
    logic [2:0]  imm_src = '0;
    logic        out_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    exp_t q[2][$];

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32)) if32 ();
    imm_gen_pipe_if #(.XLEN(64)) if64 ();

    assign if32.flush     = flush;
    assign if32.in_valid  = in_valid;
    assign if32.instr     = instr;
    assign if32.imm_src   = imm_src;
    assign if32.out_ready = out_ready;
    assign if64.flush     = flush;
    assign if64.in_valid  = in_valid;
    assign if64.instr     = instr;
    assign if64.imm_src   = imm_src;
    assign if64.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));
    imm_gen_pipe #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(if64.slave));

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    // Immediate value from the format rules as plain integer arithmetic.
    function automatic exp_t ref_model(input logic [31:0] w, input logic [2:0] sel, input int xlen);
        longint x;
        exp_t   r;
        r.err = 1'b0;
        case (sel)
            3'd0: begin x = longint'(w[31:20]); if (w[31]) x -= 4096; end
            3'd1: begin x = longint'({w[31:25], w[11:7]}); if (w[31]) x -= 4096; end
            3'd2: begin x = longint'({w[31], w[7], w[30:25], w[11:8], 1'b0}); if (w[31]) x -= 8192; end
            3'd3: begin x = longint'({w[31], w[19:12], w[20], w[30:21], 1'b0}); if (w[31]) x -= 2097152; end
            3'd4: begin x = longint'(w[31:12]) * 4096; if (w[31]) x -= 64'sh1_0000_0000; end
            3'd5: x = (xlen == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
            3'd6: x = longint'(w[19:15]);
            default: begin x = 0; r.err = 1'b1; end
        endcase
        r.imm = 64'(x);
        if (xlen == 32) r.imm[63:32] = '0;
        return r;
    endfunction

    // One cycle of stimulus, entered and left at posedge+1.
    task automatic step(input logic v, input logic [31:0] w, input logic [2:0] s,
                        input logic ordy, input logic fl);
        in_valid  = v;
        instr     = w;
        imm_src   = s;
        out_ready = ordy;
        flush     = fl;
        if (v && if32.in_ready && !fl) begin
            q[0].push_back(ref_model(w, s, 32));
            q[1].push_back(ref_model(w, s, 64));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [63:0] e32, input logic [63:0] e64,
                              input logic err);
        check({name, ".valid32"}, 64'(if32.out_valid), 64'd1);
        check({name, ".imm32"},   {32'b0, if32.imm},   e32);
        check({name, ".err32"},   64'(if32.imm_err),   64'(err));
        check({name, ".valid64"}, 64'(if64.out_valid), 64'd1);
        check({name, ".imm64"},   if64.imm,            e64);
        check({name, ".err64"},   64'(if64.imm_err),   64'(err));
    endtask

    task automatic expect_idle(input string name);
        check({name, ".valid32"}, 64'(if32.out_valid), 64'd0);
        check({name, ".valid64"}, 64'(if64.out_valid), 64'd0);
        check({name, ".ready32"}, 64'(if32.in_ready),  64'd1);
        check({name, ".ready64"}, 64'(if64.in_ready),  64'd1);
    endtask

    // Scoreboard monitor: compares every output fire, checks stall stability.
    logic        prev_stall [2];
    logic [63:0] prev_imm   [2];
    logic        prev_err   [2];

    always @(negedge clk) begin
        logic        ov;
        logic [63:0] im;
        logic        er;
        exp_t        e;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                prev_stall[i] = 1'b0;
            end else begin
                ov = (i == 0) ? if32.out_valid : if64.out_valid;
                im = (i == 0) ? {32'b0, if32.imm} : if64.imm;
                er = (i == 0) ? if32.imm_err : if64.imm_err;
                if (prev_stall[i]) begin
                    check($sformatf("stall_hold%0d", i), {ov, er, im[61:0]},
                          {1'b1, prev_err[i], prev_imm[i][61:0]});
                end
                if (ov && out_ready) begin
                    if (q[i].size() == 0) begin
                        check($sformatf("unexpected_out%0d", i), 64'(ov), 64'd0);
                    end else begin
                        e = q[i].pop_front();
                        check($sformatf("sb_imm%0d", i), im, e.imm);
                        check($sformatf("sb_err%0d", i), 64'(er), 64'(e.err));
                    end
                end
                if (flush) q[i].delete();
                prev_stall[i] = ov && !out_ready && !flush;
                prev_imm[i]   = im;
                prev_err[i]   = er;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    localparam logic [31:0] W_A = 32'h0010_0013;
    localparam logic [31:0] W_B = 32'h0020_0013;
    localparam logic [31:0] W_C = 32'h0030_0013;

    initial begin
        // Reset state
        #3;
        check("rst.valid", 64'(if32.out_valid), 64'd0);
        check("rst.ready", 64'(if32.in_ready), 64'd1);
        check("rst.imm32", {32'b0, if32.imm}, 64'd0);
        check("rst.imm64", if64.imm, 64'd0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Format sweep, back-to-back with out_ready=1
        step(1, 32'hFFF0_0093, 3'b000, 1, 0);
        expect_out("fmt_i", 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        step(1, 32'hFE00_0EE3, 3'b010, 1, 0);
        expect_out("fmt_b", 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 0);
        step(1, 32'h0080_006F, 3'b011, 1, 0);
        expect_out("fmt_j", 64'h8, 64'h8, 0);
        step(1, 32'h1234_5678, 3'b111, 1, 0);
        expect_out("fmt_rsvd", 64'h0, 64'h0, 1);
        step(1, 32'h8000_00B7, 3'b100, 1, 0);
        expect_out("fmt_u", 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 0);
        step(1, 32'h03F0_9093, 3'b101, 1, 0);
        expect_out("fmt_shamt", 64'd31, 64'd63, 0);
        step(0, 32'h0, 3'b000, 1, 0);
        expect_idle("fmt_drain");

        // Stall and skid: A, B, C with out_ready low once A is visible
        step(1, W_A, 3'b000, 1, 0);
        expect_out("stall_a", 64'd1, 64'd1, 0);
        step(1, W_B, 3'b000, 0, 0);
        expect_out("stall_hold_a", 64'd1, 64'd1, 0);
        check("stall_ready_low", 64'(if32.in_ready), 64'd0);
        step(1, W_C, 3'b000, 0, 0);
        expect_out("stall_c_held", 64'd1, 64'd1, 0);
        check("stall_ready_still_low", 64'(if32.in_ready), 64'd0);
        step(1, W_C, 3'b000, 1, 0);
        expect_out("release_b", 64'd2, 64'd2, 0);
        check("release_ready", 64'(if64.in_ready), 64'd1);
        step(1, W_C, 3'b000, 1, 0);
        expect_out("release_c", 64'd3, 64'd3, 0);
        step(0, 32'h0, 3'b000, 1, 0);
        expect_idle("release_drain");

        // Flush with both entries full and in_valid high
        step(1, W_A, 3'b000, 0, 0);
        step(1, W_B, 3'b000, 0, 0);
        step(1, W_C, 3'b000, 0, 1);
        expect_idle("flush_full");
        step(0, 32'h0, 3'b000, 1, 0);
        expect_idle("flush_nothing_left");

        // Flush discards an input that would otherwise land in skid
        step(1, W_A, 3'b000, 0, 0);
        step(1, W_B, 3'b000, 0, 1);
        expect_idle("flush_skid_input");
        step(0, 32'h0, 3'b000, 1, 0);
        expect_idle("flush_skid_gone");

        // Asynchronous reset with both entries full
        step(1, W_A, 3'b000, 0, 0);
        step(1, W_B, 3'b000, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        expect_idle("rst_mid");
        check("rst_mid.imm32", {32'b0, if32.imm}, 64'd0);
        check("rst_mid.imm64", if64.imm, 64'd0);
        check("rst_mid.err", 64'(if64.imm_err), 64'd0);
        q[0].delete();
        q[1].delete();
        in_valid = 1'b0;
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(0, 32'h0, 3'b000, 1, 0);
        expect_idle("rst_mid_after");

        // Random traffic against the scoreboard
        for (int n = 0; n < 2000; n++) begin
            step(($urandom % 4) != 0, $urandom, 3'($urandom % 8),
                 ($urandom % 3) != 0, ($urandom % 25) == 0);
        end

        // Drain with a bounded budget
        for (int k = 0; k < 20 && (q[0].size() != 0 || q[1].size() != 0); k++) begin
            step(0, 32'h0, 3'b000, 1, 0);
        end
        check("drain_q32", 64'(q[0].size()), 64'd0);
        check("drain_q64", 64'(q[1].size()), 64'd0);
        expect_idle("drain_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
